wb_timeout: RTL
===============

// Module: wb_timeout
// PURPOSE
//  Wishbone bus-watchdog stage that sits directly downstream of wb_arbiter_2 (its wbs_* port feeds wbm_* here).
//  Forwards cycles to a single slave. If the slave gives no ack/err/rty within TIMEOUT cycles of stb, it aborts
//  the access: drops cyc/stb to the slave and returns err to the master. A hung slave can therefore never lock the arbiter.
// PARAMETERS
//  DATA_WIDTH    32                Data bus width.
//  ADDR_WIDTH    32                Address bus width.
//  SELECT_WIDTH  DATA_WIDTH/8      Byte-select width.
//  CNT_WIDTH     16                Watchdog counter width.
//  TIMEOUT       1024              Cycles of unanswered stb before abort; legal range 1..2**CNT_WIDTH-1.
// PORTS
//  clk            in   1             Clock; all logic is rising-edge.
//  rst            in   1             Synchronous reset, active-high.
//  wbm_adr_i      in   ADDR_WIDTH    Master address.
//  wbm_dat_i      in   DATA_WIDTH    Master write data.
//  wbm_dat_o      out  DATA_WIDTH    Read data to master (= wbs_dat_i).
//  wbm_we_i       in   1             Master write enable.
//  wbm_sel_i      in   SELECT_WIDTH  Master byte selects.
//  wbm_stb_i      in   1             Master strobe.
//  wbm_ack_o      out  1             Ack to master.
//  wbm_err_o      out  1             Err to master (slave err OR timeout abort).
//  wbm_rty_o      out  1             Retry to master.
//  wbm_cyc_i      in   1             Master cycle.
//  wbs_adr_o      out  ADDR_WIDTH    Slave address (= wbm_adr_i).
//  wbs_dat_i      in   DATA_WIDTH    Slave read data.
//  wbs_dat_o      out  DATA_WIDTH    Slave write data (= wbm_dat_i).
//  wbs_we_o       out  1             Slave write enable.
//  wbs_sel_o      out  SELECT_WIDTH  Slave byte selects.
//  wbs_stb_o      out  1             Slave strobe (gated).
//  wbs_ack_i      in   1             Slave ack.
//  wbs_err_i      in   1             Slave err.
//  wbs_rty_i      in   1             Slave retry.
//  wbs_cyc_o      out  1             Slave cycle (gated).
//  timeout_o      out  1             One-cycle pulse, coincident with an abort err.
// BEHAVIOUR
//  - Adr/dat/we/sel are combinational pass-through in every state. Gating applies only to cyc, stb, ack, err and rty.
//  - FSM with states PASS, ABORT, RECOVER. Reset -> PASS, counter = 0, timeout_o = 0.
//  - PASS:
//    - wbs_cyc_o = wbm_cyc_i and wbs_stb_o = wbm_stb_i.
//    - wbm_ack/err/rty_o = wbs_ack/err/rty_i. Zero added latency.
//  - Counter, in PASS:
//    - Cleared when wbm_stb_i = 0 or any slave termination (ack|err|rty) is seen.
//    - Otherwise increments by 1 per cycle.
//  - Abort trigger: counter == TIMEOUT-1 with wbm_cyc_i & wbm_stb_i = 1 and no termination in that cycle
//    -> next state ABORT.
//    - TIMEOUT = 1 therefore aborts one cycle after an unanswered stb.
//  - Termination priority: a slave ack/err/rty in the same cycle the counter reaches TIMEOUT-1 wins. The access
//    completes normally and there is no abort.
//  - ABORT (exactly one cycle):
//    - wbs_cyc_o = wbs_stb_o = 0.
//    - wbm_err_o = 1, wbm_ack_o = wbm_rty_o = 0, timeout_o = 1.
//    - Any slave termination in this cycle is discarded.
//    - Next state RECOVER.
//  - RECOVER:
//    - wbs_cyc_o = wbs_stb_o = 0 and all master terminations = 0, so late slave responses are swallowed.
//    - Moves to PASS on the first cycle with wbm_stb_i = 0. That cycle is still gated.
//  - If the master drops cyc/stb mid-count, the counter clears and no abort occurs.
//  - The counter never wraps: it saturates at TIMEOUT-1 only for the trigger cycle.
//  - rst asserted mid-access: next cycle is PASS with counter 0. Any pending abort or RECOVER state is cancelled.
// CONFIGURATION
//  - WB_TIMEOUT_STATUS_EN defined: adds the following outputs.
//    - err_adr_o [ADDR_WIDTH]: wbm_adr_i captured on the ABORT cycle; holds until the next abort.
//    - err_cnt_o [16]: abort count, saturating at 16'hFFFF.
//    - Both reset to 0.
//  - WB_TIMEOUT_STATUS_EN undefined: these ports and registers do not exist; all other behaviour is identical.
// TESTING
//  - Read, slave acks 3 cycles after stb, TIMEOUT=8: wbm_ack_o pulses with wbs_dat_i=32'hDEADBEEF; timeout_o never 1.
//  - Write to adr 32'h1000, slave never responds, TIMEOUT=8: stb high for cycles 0-7; cycle 8 has wbm_err_o=1,
//    timeout_o=1, wbs_cyc_o=0.
//  - Slave ack on exactly the TIMEOUT-1 cycle: wbm_ack_o=1, no err, FSM stays PASS.
//  - Slave asserts a late ack during RECOVER with master stb still high: wbm_ack_o stays 0. PASS resumes after stb drops.
//  - rst pulsed during a hung access at count 5: next cycle wbs_cyc_o follows wbm_cyc_i, counter=0, no err.
//  - With WB_TIMEOUT_STATUS_EN: two aborts at adr 32'h20, then 32'h40 -> err_cnt_o=2, err_adr_o=32'h40.

Source files
------------

// File: rtl/wb_timeout.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wb_timeout : Wishbone watchdog; aborts unanswered slave accesses with err.
// Optional status outputs (err_adr_o, err_cnt_o) under WB_TIMEOUT_STATUS_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
module wb_timeout #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int SELECT_WIDTH = DATA_WIDTH / 8,
  parameter int CNT_WIDTH    = 16,
  parameter int TIMEOUT      = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   wbm_adr_i,
  input  logic [DATA_WIDTH-1:0]   wbm_dat_i,
  output logic [DATA_WIDTH-1:0]   wbm_dat_o,
  input  logic                    wbm_we_i,
  input  logic [SELECT_WIDTH-1:0] wbm_sel_i,
  input  logic                    wbm_stb_i,
  output logic                    wbm_ack_o,
  output logic                    wbm_err_o,
  output logic                    wbm_rty_o,
  input  logic                    wbm_cyc_i,
  output logic [ADDR_WIDTH-1:0]   wbs_adr_o,
  input  logic [DATA_WIDTH-1:0]   wbs_dat_i,
  output logic [DATA_WIDTH-1:0]   wbs_dat_o,
  output logic                    wbs_we_o,
  output logic [SELECT_WIDTH-1:0] wbs_sel_o,
  output logic                    wbs_stb_o,
  input  logic                    wbs_ack_i,
  input  logic                    wbs_err_i,
  input  logic                    wbs_rty_i,
  output logic                    wbs_cyc_o,
  output logic                    timeout_o
`ifdef WB_TIMEOUT_STATUS_EN
  ,
  output logic [ADDR_WIDTH-1:0]   err_adr_o,
  output logic [15:0]             err_cnt_o
`endif
);

  localparam logic [CNT_WIDTH-1:0] C_LAST = CNT_WIDTH'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_PASS    = 2'd0,
    ST_ABORT   = 2'd1,
    ST_RECOVER = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 w_term;
  logic                 w_req;

  assign w_term = wbs_ack_i | wbs_err_i | wbs_rty_i;
  assign w_req  = wbm_cyc_i & wbm_stb_i;

  assign wbs_adr_o = wbm_adr_i;
  assign wbs_dat_o = wbm_dat_i;
  assign wbs_we_o  = wbm_we_i;
  assign wbs_sel_o = wbm_sel_i;
  assign wbm_dat_o = wbs_dat_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_PASS;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    wbs_cyc_o = 1'b0;
    wbs_stb_o = 1'b0;
    wbm_ack_o = 1'b0;
    wbm_err_o = 1'b0;
    wbm_rty_o = 1'b0;
    timeout_o = 1'b0;
    case (state_q)
      ST_PASS: begin
        wbs_cyc_o = wbm_cyc_i;
        wbs_stb_o = wbm_stb_i;
        wbm_ack_o = wbs_ack_i;
        wbm_err_o = wbs_err_i;
        wbm_rty_o = wbs_rty_i;
        // A termination on the last counted cycle wins over the abort.
        if (!w_req || w_term) begin
          cnt_d = '0;
        end else if (cnt_q == C_LAST) begin
          cnt_d   = '0;
          state_d = ST_ABORT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_ABORT: begin
        wbm_err_o = 1'b1;
        timeout_o = 1'b1;
        state_d   = ST_RECOVER;
      end
      ST_RECOVER: begin
        if (!wbm_stb_i) state_d = ST_PASS;
      end
      default: state_d = ST_PASS;
    endcase
  end

`ifdef WB_TIMEOUT_STATUS_EN
  logic [ADDR_WIDTH-1:0] err_adr_q;
  logic [15:0]           err_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_adr_q <= '0;
      err_cnt_q <= '0;
    end else if (state_q == ST_ABORT) begin
      err_adr_q <= wbm_adr_i;
      if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign err_adr_o = err_adr_q;
  assign err_cnt_o = err_cnt_q;
`endif

endmodule
`default_nettype wire
